// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer.
// Computes A+B or A-B over WORDS 16-bit words using one 16-bit CLA slice.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       operand handshake (a_i, b_i, op_sub)
//   out_valid/out_ready     result handshake (result_o, carry_o, ovf_o, zero_o)
//   op_sub                  0 = A+B, 1 = A-B
//   a_i, b_i                16*WORDS-bit operands
//   result_o                sum/difference modulo 2^(16*WORDS)
//   carry_o                 final carry (for subtract: 1 = no borrow)
//   ovf_o                   signed two's-complement overflow
//   zero_o                  result_o == 0
module mp_addsub_seq #(
  parameter  int WORDS = 4,
  localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic [16*WORDS-1:0] a_i,
  input  logic [16*WORDS-1:0] b_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16*WORDS-1:0] result_o,
  output logic              carry_o,
  output logic              ovf_o,
  output logic              zero_o
);

  localparam int W = 16 * WORDS;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic            zacc;

  logic [15:0]     aw;
  logic [15:0]     bw;
  logic [15:0]     g;
  logic [15:0]     p;
  logic [3:0]      gg;
  logic [3:0]      gp;
  logic [4:0]      gc;
  logic [16:0]     c;
  logic [15:0]     sum;
  logic            cout;
  logic            c15;
  logic            sum_z;

  // Word select for the current index.
  always_comb begin
    aw = '0;
    bw = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == IDXW'(w)) begin
        aw = a_q[16*w +: 16];
        bw = b_q[16*w +: 16];
      end
    end
    // Subtract is A + ~B + 1; the +1 enters via the initial carry.
    bw = bw ^ {16{sub_q}};
  end

  // 16-bit carry-lookahead slice: four 4-bit groups with a
  // second-level lookahead across the group carries.
  always_comb begin
    g  = aw & bw;
    p  = aw ^ bw;
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end

    gc    = '0;
    gc[0] = carry;
    gc[1] = gg[0]
          | (gp[0] & gc[0]);
    gc[2] = gg[1]
          | (gp[1] & gg[0])
          | (gp[1] & gp[0] & gc[0]);
    gc[3] = gg[2]
          | (gp[2] & gg[1])
          | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & gc[0]);
    gc[4] = gg[3]
          | (gp[3] & gg[2])
          | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);

    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k]
               | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[16] = gc[4];

    sum   = p ^ c[15:0];
    cout  = c[16];
    c15   = c[15];
    sum_z = ~|sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      zacc      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result_o  <= '0;
      carry_o   <= 1'b0;
      ovf_o     <= 1'b0;
      zero_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a_i;
            b_q      <= b_i;
            sub_q    <= op_sub;
            idx      <= '0;
            carry    <= op_sub;
            zacc     <= 1'b1;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx == IDXW'(w)) begin
              result_o[16*w +: 16] <= sum;
            end
          end
          carry <= cout;
          zacc  <= zacc & sum_z;
          if (idx == LAST) begin
            idx       <= '0;
            carry_o   <= cout;
            ovf_o     <= c15 ^ cout;
            // zacc covers the words written earlier in this run.
            zero_o    <= zacc & sum_z;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Testbench for mp_addsub_seq: WORDS=4 and WORDS=1 instances,
// directed cases plus randomized ops against an arithmetic model.
module tb_mp_addsub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv;
  logic        sel1;
  logic        out_ready;
  logic        op_sub;
  logic [63:0] a_bus;
  logic [63:0] b_bus;

  logic        iv4;
  logic        iv1;
  assign iv4 = iv & ~sel1;
  assign iv1 = iv & sel1;

  logic        rdy4, vld4, c4, v4, z4;
  logic [63:0] res4;
  logic        rdy1, vld1, c1, v1, z1;
  logic [15:0] res1;

  mp_addsub_seq #(.WORDS(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(rdy4),
    .op_sub(op_sub), .a_i(a_bus), .b_i(b_bus),
    .out_valid(vld4), .out_ready(out_ready),
    .result_o(res4), .carry_o(c4), .ovf_o(v4), .zero_o(z4)
  );

  mp_addsub_seq #(.WORDS(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(rdy1),
    .op_sub(op_sub), .a_i(a_bus[15:0]), .b_i(b_bus[15:0]),
    .out_valid(vld1), .out_ready(out_ready),
    .result_o(res1), .carry_o(c1), .ovf_o(v1), .zero_o(z1)
  );

  logic        mrdy, mvld, mc, mv, mz;
  logic [63:0] mres;
  assign mrdy = sel1 ? rdy1 : rdy4;
  assign mvld = sel1 ? vld1 : vld4;
  assign mc   = sel1 ? c1 : c4;
  assign mv   = sel1 ? v1 : v4;
  assign mz   = sel1 ? z1 : z4;
  assign mres = sel1 ? {48'b0, res1} : res4;

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] mask_of(input bit w1);
    return w1 ? 64'h0000_0000_0000_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // Reference: plain unsigned/signed arithmetic on the full width.
  task automatic model(input bit w1, input logic [63:0] a_in,
                       input logic [63:0] b_in, input bit sub,
                       output logic [63:0] r, output logic c,
                       output logic v, output logic z);
    logic [63:0] m;
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] s;
    int top;
    m   = mask_of(w1);
    a   = a_in & m;
    b   = b_in & m;
    top = w1 ? 15 : 63;
    if (!sub) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[63:0] & m;
      c = w1 ? s[16] : s[64];
      v = (a[top] == b[top]) && (r[top] != a[top]);
    end else begin
      r = (a - b) & m;
      c = (a >= b);
      v = (a[top] != b[top]) && (r[top] != a[top]);
    end
    z = (r == 64'd0);
  endtask

  function automatic logic [63:0] pick(input bit w1);
    logic [63:0] msb;
    logic [63:0] x;
    msb = w1 ? 64'h8000 : 64'h8000_0000_0000_0000;
    case ($urandom_range(0, 6))
      0: x = 64'd0;
      1: x = '1;
      2: x = msb;
      3: x = msb - 64'd1;
      4: x = 64'($urandom_range(0, 3));
      5: x = {32'hFFFF_FFFF, 16'hFFFF, 16'($urandom)};
      default: x = {$urandom, $urandom};
    endcase
    return x & mask_of(w1);
  endfunction

  task automatic scramble();
    a_bus  = {$urandom, $urandom};
    b_bus  = {$urandom, $urandom};
    op_sub = 1'($urandom);
  endtask

  // Runs one operation; checks handshake, latency and stability.
  task automatic do_op(input bit w1, input logic [63:0] a,
                       input logic [63:0] b, input bit sub,
                       input int hold, input bit noisy,
                       output logic [63:0] r, output logic c,
                       output logic v, output logic z);
    int lat;
    bit got;
    sel1      = w1;
    out_ready = (hold == 0);
    a_bus     = a;
    b_bus     = b;
    op_sub    = sub;
    iv        = 1'b1;
    #1;
    checks++;
    if (mrdy !== 1'b1 || mvld !== 1'b0) begin
      errors++;
      $display("FAIL pre_accept rdy=%b vld=%b want 1/0", mrdy, mvld);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mrdy !== 1'b0 || mvld !== 1'b0) begin
      errors++;
      $display("FAIL post_accept rdy=%b vld=%b want 0/0", mrdy, mvld);
    end
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      if (noisy) begin
        iv = 1'($urandom);
        scramble();
      end else begin
        iv = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      got = mvld;
    end
    checks++;
    if (!got || lat != (w1 ? 1 : 4)) begin
      errors++;
      $display("FAIL latency got=%0d cycles want %0d", lat, w1 ? 1 : 4);
    end
    r = mres;
    c = mc;
    v = mv;
    z = mz;
    repeat (hold) begin
      iv = 1'($urandom);
      scramble();
      @(posedge clk);
      #1;
      checks++;
      if (mvld !== 1'b1 || mrdy !== 1'b0 || mres !== r ||
          mc !== c || mv !== v || mz !== z) begin
        errors++;
        $display("FAIL hold vld=%b rdy=%b res=%h want 1/0 res=%h",
                 mvld, mrdy, mres, r);
      end
    end
    out_ready = 1'b1;
    iv        = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mvld !== 1'b0 || mrdy !== 1'b1) begin
      errors++;
      $display("FAIL release vld=%b rdy=%b want 0/1", mvld, mrdy);
    end
  endtask

  task automatic expect_res(input string name,
                            input logic [63:0] r, input logic c,
                            input logic v, input logic z,
                            input logic [63:0] er, input logic ec,
                            input logic ev, input logic ez);
    checks++;
    if (r !== er || c !== ec || v !== ev || z !== ez) begin
      errors++;
      $display("FAIL %s got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
               name, r, c, v, z, er, ec, ev, ez);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    iv        = 1'b0;
    sel1      = 1'b0;
    out_ready = 1'b0;
    op_sub    = 1'b0;
    a_bus     = '0;
    b_bus     = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy4 !== 1'b1 || vld4 !== 1'b0 || res4 !== 64'd0 ||
        c4 !== 1'b0 || v4 !== 1'b0 || z4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w4 rdy=%b vld=%b res=%h c=%b v=%b z=%b want 1/0/0/0/0/0",
               rdy4, vld4, res4, c4, v4, z4);
    end
    checks++;
    if (rdy1 !== 1'b1 || vld1 !== 1'b0 || res1 !== 16'd0 ||
        c1 !== 1'b0 || v1 !== 1'b0 || z1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w1 rdy=%b vld=%b res=%h c=%b v=%b z=%b want 1/0/0/0/0/0",
               rdy1, vld1, res1, c1, v1, z1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [63:0] r;
    logic c, v, z;
    do_op(0, 64'h0000_0000_0000_FFFF, 64'h1, 0, 0, 0, r, c, v, z);
    expect_res("add_word_carry", r, c, v, z,
               64'h0000_0000_0001_0000, 0, 0, 0);
    do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 0, r, c, v, z);
    expect_res("full_ripple", r, c, v, z, 64'h0, 1, 0, 1);
    do_op(0, 64'h1, 64'h2, 1, 0, 0, r, c, v, z);
    expect_res("sub_borrow", r, c, v, z,
               64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    do_op(0, 64'h8000_0000_0000_0000, 64'h1, 1, 0, 0, r, c, v, z);
    expect_res("sub_ovf", r, c, v, z,
               64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0);
    do_op(1, 64'h7FFF, 64'h1, 0, 0, 0, r, c, v, z);
    expect_res("w1_add_ovf", r, c, v, z, 64'h8000, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    logic [63:0] r, er;
    logic c, v, z, ec, ev, ez;
    model(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1,
          er, ec, ev, ez);
    do_op(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1,
          10, 1, r, c, v, z);
    expect_res("backpressure", r, c, v, z, er, ec, ev, ez);
  endtask

  task automatic test_reset_mid();
    logic [63:0] r;
    logic c, v, z;
    bit seen;
    sel1      = 1'b0;
    out_ready = 1'b1;
    a_bus     = 64'h1111_2222_3333_4444;
    b_bus     = 64'h0101_0101_0101_0101;
    op_sub    = 1'b0;
    iv        = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (res4[31:0] !== 32'h3434_4545) begin
      errors++;
      $display("FAIL mid_partial res=%h want low 32 bits 34344545", res4);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (rdy4 !== 1'b1 || vld4 !== 1'b0 || res4 !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid rdy=%b vld=%b res=%h want 1/0/0",
               rdy4, vld4, res4);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (vld4 === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_abort out_valid=1 want 0");
    end
    do_op(0, 64'h5, 64'h7, 0, 0, 0, r, c, v, z);
    expect_res("after_reset_add", r, c, v, z, 64'hC, 0, 0, 0);
  endtask

  task automatic test_random(input bit w1, input int n);
    logic [63:0] a, b, r, er;
    logic c, v, z, ec, ev, ez;
    bit sub;
    int hold;
    for (int i = 0; i < n; i++) begin
      a    = pick(w1);
      b    = pick(w1);
      sub  = 1'($urandom);
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      model(w1, a, b, sub, er, ec, ev, ez);
      do_op(w1, a, b, sub, hold, 1'($urandom), r, c, v, z);
      checks++;
      if (r !== er || c !== ec || v !== ev || z !== ez) begin
        errors++;
        $display("FAIL rand_w%0d a=%h b=%h sub=%b got %h %b%b%b want %h %b%b%b",
                 w1 ? 1 : 4, a, b, sub, r, c, v, z, er, ec, ev, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random(0, 1000);
    test_random(1, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
